quadrature_step_decoder: RTL and testbench



---
 rtl/quad_pkg.sv | 45 ++++
 rtl/quad_glitch_filter.sv | 60 ++++++
 rtl/quadrature_step_decoder.sv | 129 ++++++++++++
 tb/tb_quadrature_step_decoder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature step decoder: FSM encoding,
// Gray-code phase constants and the transition classifier.
package quad_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_e;

  // Gray phases in forward order: 00 -> 01 -> 11 -> 10 -> 00.
  localparam logic [1:0] PH_0 = 2'b00;
  localparam logic [1:0] PH_1 = 2'b01;
  localparam logic [1:0] PH_2 = 2'b11;
  localparam logic [1:0] PH_3 = 2'b10;

  typedef enum logic [1:0] {
    TR_NONE    = 2'd0,
    TR_FWD     = 2'd1,
    TR_REV     = 2'd2,
    TR_ILLEGAL = 2'd3
  } trans_e;

  // Position of a Gray phase along the forward sequence.
  function automatic logic [1:0] phase_index(input logic [1:0] ab);
    case (ab)
      PH_0:    return 2'd0;
      PH_1:    return 2'd1;
      PH_2:    return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // Modulo-4 phase distance: +1 is forward, -1 is reverse, 2 is a skipped phase.
  function automatic trans_e classify(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
    logic [1:0] delta;
    delta = phase_index(cur_ab) - phase_index(prev_ab);
    case (delta)
      2'd0:    return TR_NONE;
      2'd1:    return TR_FWD;
      2'd3:    return TR_REV;
      default: return TR_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// One encoder channel: plain synchronizer chain followed by a stability
// filter that only accepts a new level after FILTER_LEN disagreeing cycles.
module quad_glitch_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,        // bypass the filter and follow the synchronizer
  input  logic raw_in,
  output logic level,       // accepted (filtered) level
  output logic level_next   // value level takes on the next edge
);

  // The counter never needs to hold FILTER_LEN: it clears on acceptance.
  localparam int              CNT_W    = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_out;
  logic                   filt_q, filt_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Shift the synchronizer and decide whether the filtered level moves.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    sync_d = {sync_q[SYNC_STAGES-2:0], raw_in};
    filt_d = filt_q;
    cnt_d  = '0;
    if (load) begin
      filt_d = sync_out;
    end else if (sync_out != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync_out;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so the chain shifts by exactly one stage per clock.
    if (rst) begin
      sync_q <= '0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign level      = filt_q;
  assign level_next = filt_d;

endmodule

// File: rtl/quadrature_step_decoder.sv
// Converts raw quadrature A/B into a one-cycle step strobe plus direction,
// flags skipped Gray phases and keeps a saturating count of them.
module quadrature_step_decoder
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_LEN    = 4,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     quad_a,
  input  logic                     quad_b,
  input  logic                     clear_err,
  output logic                     step,
  output logic                     dir,
  output logic                     illegal,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic                     ready
);

  localparam int                INIT_CYCLES = SYNC_STAGES + FILTER_LEN;
  localparam int                INIT_W      = $clog2(INIT_CYCLES);
  localparam logic [INIT_W-1:0] INIT_LAST   = INIT_W'(INIT_CYCLES - 1);

  logic filt_a, filt_b, next_a, next_b, init_load;

  state_e                   state_q, state_d;
  logic [INIT_W-1:0]        init_cnt_q, init_cnt_d;
  logic [1:0]               prev_ab_q, prev_ab_d;
  logic                     step_q, step_d;
  logic                     dir_q, dir_d;
  logic                     illegal_q, illegal_d;
  logic [ERR_CNT_WIDTH-1:0] err_q, err_d;
  logic                     ready_q, ready_d;
  logic [1:0]               cur_ab;
  trans_e                   trans;

  assign init_load = (state_q == ST_INIT);
  assign cur_ab    = {filt_a, filt_b};

  quad_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk(clk), .rst(rst), .load(init_load), .raw_in(quad_a),
    .level(filt_a), .level_next(next_a)
  );

  quad_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk(clk), .rst(rst), .load(init_load), .raw_in(quad_b),
    .level(filt_b), .level_next(next_b)
  );

  // Next-state logic: settle during INIT, then classify each phase change.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    prev_ab_d  = prev_ab_q;
    step_d     = 1'b0;
    dir_d      = dir_q;
    illegal_d  = 1'b0;
    err_d      = err_q;
    ready_d    = ready_q;
    trans      = TR_NONE;

    case (state_q)
      ST_INIT: begin
        // Track the level the filters are loading, so the first TRACK
        // comparison sees no change for whatever level was present at reset.
        prev_ab_d = {next_a, next_b};
        if (init_cnt_q == INIT_LAST) begin
          state_d    = ST_TRACK;
          ready_d    = 1'b1;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + INIT_W'(1);
        end
      end
      ST_TRACK: begin
        trans     = classify(prev_ab_q, cur_ab);
        prev_ab_d = cur_ab;
        case (trans)
          TR_FWD, TR_REV: begin
            step_d = en;
            if (en) dir_d = (trans == TR_FWD);
          end
          TR_ILLEGAL: begin
            illegal_d = 1'b1;
            if (err_q != '1) err_d = err_q + ERR_CNT_WIDTH'(1);
          end
          default: ;
        endcase
      end
      default: state_d = ST_INIT;
    endcase

    // Clearing beats a simultaneous increment.
    if (clear_err) err_d = '0;
  end

  // FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      prev_ab_q  <= 2'b00;
      step_q     <= 1'b0;
      dir_q      <= 1'b1;
      illegal_q  <= 1'b0;
      err_q      <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      prev_ab_q  <= prev_ab_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      illegal_q  <= illegal_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
    end
  end

  assign step      = step_q;
  assign dir       = dir_q;
  assign illegal   = illegal_q;
  assign err_count = err_q;
  assign ready     = ready_q;

endmodule

// File: tb/tb_quadrature_step_decoder.sv
// Scoreboard bench for quadrature_step_decoder: each input change pushes the
// expected step/illegal event; a negedge monitor pops and compares it.
module tb_quadrature_step_decoder;

  logic       clk = 1'b0;
  logic       rst, en, quad_a, quad_b, clear_err;
  logic       step, dir, illegal, ready;
  logic [7:0] err_count;
  logic       step_s, dir_s, illegal_s, ready_s;
  logic [1:0] err_count_s;

  quadrature_step_decoder dut (
    .clk(clk), .rst(rst), .en(en), .quad_a(quad_a), .quad_b(quad_b),
    .clear_err(clear_err), .step(step), .dir(dir), .illegal(illegal),
    .err_count(err_count), .ready(ready)
  );

  quadrature_step_decoder #(.ERR_CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .quad_a(quad_a), .quad_b(quad_b),
    .clear_err(clear_err), .step(step_s), .dir(dir_s), .illegal(illegal_s),
    .err_count(err_count_s), .ready(ready_s)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int cyc;
    bit is_illegal;
    bit dir;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_ev;
  logic [1:0] cur_ab;
  bit         exp_dir;
  int         err_model, sat_model, step_seen;
  logic [3:0] tb_ctr;

  // Monitor: every step/illegal pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (step === 1'b1 || illegal === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL spurious_event: cyc=%0d step=%b illegal=%b, required no event", cyc, step, illegal);
      end else begin
        mon_ev = exp_q.pop_front();
        if (mon_ev.cyc != cyc || illegal !== mon_ev.is_illegal || step !== ~mon_ev.is_illegal || dir !== mon_ev.dir)
          $display("FAIL event: cyc=%0d step=%b illegal=%b dir=%b, required cyc=%0d illegal=%b dir=%b",
                   cyc, step, illegal, dir, mon_ev.cyc, mon_ev.is_illegal, mon_ev.dir);
        else
          n_pass++;
      end
    end
  end

  function automatic logic [1:0] fwd_next(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Drive a new AB level just after a falling edge, push the expected event
  // (7 rising edges later), then run 10 cycles. With clr, clear_err is high
  // on exactly the edge that registers the illegal pulse.
  task automatic apply(input logic [1:0] ab, input bit clr);
    int k;
    bit fwd, rev, ill;
    fwd = (ab == fwd_next(cur_ab));
    rev = (cur_ab == fwd_next(ab));
    ill = (ab != cur_ab) && !fwd && !rev;
    {quad_a, quad_b} = ab;
    k = cyc;
    if (ill) begin
      exp_q.push_back('{k + 7, 1'b1, exp_dir});
      if (clr) begin
        err_model = 0;
        sat_model = 0;
      end else begin
        if (err_model < 255) err_model++;
        if (sat_model < 3)   sat_model++;
      end
    end else if ((fwd || rev) && en) begin
      exp_dir = fwd;
      exp_q.push_back('{k + 7, 1'b0, exp_dir});
    end
    cur_ab = ab;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (clr) clear_err = (i == 6);
      if (step === 1'b1) begin
        step_seen++;
        tb_ctr = dir ? tb_ctr + 4'd1 : tb_ctr - 4'd1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; quad_a = 1'b0; quad_b = 1'b0; clear_err = 1'b0;
    cur_ab = 2'b00; exp_dir = 1'b1; err_model = 0; sat_model = 0; step_seen = 0; tb_ctr = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({step, dir, illegal, ready} !== 4'b0100) $display("FAIL reset_outputs: step,dir,illegal,ready=%b, required 0100", {step, dir, illegal, ready});
    else n_pass++;
    n_checks++;
    if (err_count !== 8'd0 || err_count_s !== 2'd0) $display("FAIL reset_err: got %0d/%0d, required 0/0", err_count, err_count_s);
    else n_pass++;
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (step === 1'b1) step_seen++;
      if (i == 5) begin
        n_checks++;
        if (ready !== 1'b0) $display("FAIL ready_early: ready=%b after 5 cycles, required 0", ready);
        else n_pass++;
      end
      if (i == 6) begin
        n_checks++;
        if (ready !== 1'b1 || ready_s !== 1'b1) $display("FAIL ready_on_time: ready=%b/%b after 6 cycles, required 1/1", ready, ready_s);
        else n_pass++;
      end
    end
    n_checks++;
    if (step_seen != 0 || dir !== 1'b1 || err_count !== 8'd0)
      $display("FAIL idle_after_reset: steps=%0d dir=%b err=%0d, required 0 1 0", step_seen, dir, err_count);
    else n_pass++;
  endtask

  task automatic test_forward();
    step_seen = 0; tb_ctr = '0;
    apply(2'b01, 1'b0);
    apply(2'b11, 1'b0);
    apply(2'b10, 1'b0);
    apply(2'b00, 1'b0);
    n_checks++;
    if (step_seen != 4 || tb_ctr !== 4'd4 || dir !== 1'b1)
      $display("FAIL forward: steps=%0d counter=%0d dir=%b, required 4 4 1", step_seen, tb_ctr, dir);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL forward_missing: %0d events outstanding, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_glitch();
    step_seen = 0;
    quad_a = 1'b1;
    repeat (3) @(negedge clk);
    quad_a = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (step === 1'b1 || illegal === 1'b1) step_seen++;
    end
    n_checks++;
    if (dut.u_filt_a.cnt_q !== 2'd0 || dut.u_filt_a.level !== 1'b0 || step_seen != 0)
      $display("FAIL glitch: cnt=%0d level=%b events=%0d, required 0 0 0", dut.u_filt_a.cnt_q, dut.u_filt_a.level, step_seen);
    else n_pass++;
  endtask

  task automatic test_reverse();
    step_seen = 0; tb_ctr = '0;
    apply(2'b10, 1'b0);
    n_checks++;
    if (tb_ctr !== 4'd15 || dir !== 1'b0) $display("FAIL reverse_first: counter=%0d dir=%b, required 15 0", tb_ctr, dir);
    else n_pass++;
    apply(2'b11, 1'b0);
    apply(2'b01, 1'b0);
    apply(2'b00, 1'b0);
    n_checks++;
    if (step_seen != 4 || tb_ctr !== 4'd12 || dir !== 1'b0)
      $display("FAIL reverse: steps=%0d counter=%0d dir=%b, required 4 12 0", step_seen, tb_ctr, dir);
    else n_pass++;
  endtask

  task automatic test_illegal_clear();
    step_seen = 0;
    apply(2'b11, 1'b0);
    n_checks++;
    if (err_count !== 8'(err_model) || step_seen != 0 || dir !== exp_dir)
      $display("FAIL illegal: err=%0d steps=%0d dir=%b, required %0d 0 %b", err_count, step_seen, dir, err_model, exp_dir);
    else n_pass++;
    apply(2'b00, 1'b1);
    n_checks++;
    if (err_count !== 8'(err_model) || err_count_s !== 2'(sat_model))
      $display("FAIL clear_wins: err=%0d/%0d, required %0d/%0d", err_count, err_count_s, err_model, sat_model);
    else n_pass++;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) apply((i % 2 == 0) ? 2'b11 : 2'b00, 1'b0);
    n_checks++;
    if (err_count_s !== 2'(sat_model) || err_count_s !== 2'd3)
      $display("FAIL saturate: err=%0d, required 3", err_count_s);
    else n_pass++;
    n_checks++;
    if (err_count !== 8'(err_model)) $display("FAIL err_count_wide: err=%0d, required %0d", err_count, err_model);
    else n_pass++;
  endtask

  task automatic test_enable();
    step_seen = 0;
    en = 1'b0;
    apply(2'b10, 1'b0);
    n_checks++;
    if (step_seen != 0 || dir !== 1'b0) $display("FAIL en_off: steps=%0d dir=%b, required 0 0", step_seen, dir);
    else n_pass++;
    en = 1'b1;
    apply(2'b00, 1'b0);
    n_checks++;
    if (step_seen != 1 || dir !== 1'b1) $display("FAIL en_on: steps=%0d dir=%b, required 1 1", step_seen, dir);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    step_seen = 0;
    quad_a = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    exp_dir = 1'b1; err_model = 0; sat_model = 0; cur_ab = 2'b10;
    n_checks++;
    if ({step, dir, illegal, ready} !== 4'b0100 || err_count !== 8'd0)
      $display("FAIL mid_reset: step,dir,illegal,ready=%b err=%0d, required 0100 0", {step, dir, illegal, ready}, err_count);
    else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (step === 1'b1) step_seen++;
    end
    n_checks++;
    if (ready !== 1'b1 || step_seen != 0 || exp_q.size() != 0)
      $display("FAIL after_mid_reset: ready=%b steps=%0d pending=%0d, required 1 0 0", ready, step_seen, exp_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_glitch();
    test_reverse();
    test_illegal_clear();
    test_saturation();
    test_enable();
    test_mid_reset();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL final_drain: %0d events outstanding, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
